vout_line_fetcher: RTL and testbench

- Downstream consumer of the timing generator's `vs/hs/de/de_re` outputs.
- Issues one line-read request per active line to the frame-buffer reader (req/ack handshake).
- Pops pixels from the reader's output FIFO using the 2-cycle-early `de_re`.
- Emits RGB plus sync signals aligned for the HDMI/LCD output stage, with underflow substitution and status counters.

---
 rtl/vout_line_fetcher.sv | 148 ++++++++++++++
 tb/tb_vout_line_fetcher.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vout_line_fetcher.sv
// Line fetcher: one line-read request per active line, de_re-driven FIFO pops, synced RGB out.
// Pixel latency 3 cycles from de_re_in; FIFO starvation substitutes UNDERFLOW_COLOR, never stalls.
module vout_line_fetcher #(
  parameter int DATA_W = 24,
  parameter int Y_BITS = 12,
  parameter int V_ACT  = 1080,
  parameter int CNT_W  = 16,
  parameter logic [DATA_W-1:0] BLANK_COLOR     = 24'h000000,
  parameter logic [DATA_W-1:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic              de_re_in,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              line_req,
  output logic [Y_BITS-1:0] line_req_y,
  input  logic              line_req_ack,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [DATA_W-1:0] rgb_out,
  output logic              underflow,
  output logic [CNT_W-1:0]  underflow_cnt,
  output logic              req_overrun,
  input  logic              stat_clr
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [Y_BITS-1:0] V_ACT_Y = Y_BITS'(V_ACT);

  state_t            state, state_nxt;
  logic              vs_d;
  logic              s1_need, s1_pop, s2_need;
  logic [DATA_W-1:0] s2_dat;
  logic              t_frame, t_line, uf_now;
  logic              frame_pend;
  logic [Y_BITS-1:0] next_y;
  logic              start_req, start_frame, ack_take;

  assign fifo_rd_en = de_re_in & ~fifo_empty;
  assign uf_now     = de_re_in & ~fifo_rd_en;
  assign t_frame    = vs_in & ~vs_d;
  // s1_need is de_re_in one cycle late, so it doubles as the falling-edge detector
  assign t_line     = s1_need & ~de_re_in;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_d    <= 1'b0;
      vs_out  <= 1'b0;
      hs_out  <= 1'b0;
      de_out  <= 1'b0;
      s1_need <= 1'b0;
      s1_pop  <= 1'b0;
      s2_need <= 1'b0;
      s2_dat  <= BLANK_COLOR;
      rgb_out <= BLANK_COLOR;
    end else begin
      vs_d    <= vs_in;
      vs_out  <= vs_in;
      hs_out  <= hs_in;
      de_out  <= de_in;
      s1_need <= de_re_in;
      s1_pop  <= fifo_rd_en;
      s2_need <= s1_need;
      s2_dat  <= (s1_need & ~s1_pop) ? UNDERFLOW_COLOR : fifo_rd_data;
      rgb_out <= s2_need ? s2_dat : BLANK_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
      req_overrun   <= 1'b0;
    end else if (stat_clr) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
      req_overrun   <= 1'b0;
    end else begin
      if (uf_now) begin
        underflow <= 1'b1;
        if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + 1'b1;
      end
      if (state == REQ && (t_frame || t_line)) req_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // A pending frame start outranks any line trigger arriving in the same IDLE cycle
  always_comb begin
    state_nxt   = state;
    start_req   = 1'b0;
    start_frame = 1'b0;
    ack_take    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_pend || t_frame) begin
          state_nxt   = REQ;
          start_req   = 1'b1;
          start_frame = 1'b1;
        end else if (t_line && (next_y < V_ACT_Y)) begin
          state_nxt = REQ;
          start_req = 1'b1;
        end
      end
      REQ: begin
        if (line_req_ack) begin
          state_nxt = IDLE;
          ack_take  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_req = (state == REQ);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      next_y     <= '0;
      line_req_y <= '0;
      frame_pend <= 1'b0;
    end else begin
      if (start_frame) begin
        next_y     <= '0;
        line_req_y <= '0;
      end else begin
        if (start_req) line_req_y <= next_y;
        if (ack_take)  next_y     <= next_y + 1'b1;
      end
      if (state == REQ && t_frame) frame_pend <= 1'b1;
      else if (start_frame)        frame_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vout_line_fetcher.sv
// Scoreboard bench: a small raster generator and FIFO feed the fetcher; pixel and request monitors
// pop hand-scheduled expectations whenever de_out / a new line_req appears.
module tb_vout_line_fetcher;
  localparam int H_ACT = 16, H_TOTAL = 40, V_ACT = 6, V_TOTAL = 9;
  localparam int DATA_W = 24, Y_BITS = 12, CNT_W = 3;
  localparam logic [DATA_W-1:0] UFC = 24'hFF00FF;

  logic clk, rstn, vs_in, hs_in, de_in, de_re_in, fifo_rd_en, fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data, rgb_out;
  logic line_req, line_req_ack, vs_out, hs_out, de_out, underflow, req_overrun, stat_clr;
  logic [Y_BITS-1:0] line_req_y;
  logic [CNT_W-1:0] underflow_cnt;

  vout_line_fetcher #(.DATA_W(DATA_W), .Y_BITS(Y_BITS), .V_ACT(V_ACT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .de_re_in(de_re_in),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .line_req(line_req), .line_req_y(line_req_y), .line_req_ack(line_req_ack),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .rgb_out(rgb_out),
    .underflow(underflow), .underflow_cnt(underflow_cnt), .req_overrun(req_overrun),
    .stat_clr(stat_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int gv = V_ACT, gh = 0;
  int empty_v = -1, empty_h0 = 0, empty_len = 0;
  int hold_y = -1, hold_len = 3;
  int pix_cnt = 0;
  logic [DATA_W-1:0] data_ctr = 24'd1;
  logic [DATA_W-1:0] px_q[$];
  logic [Y_BITS-1:0] req_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic wait_pos(input int tv, input int th);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (gv == tv && gh == th) return;
    end
    fail_now("wait_pos timeout");
  endtask

  task automatic push_reqs(input int lo, input int hi);
    for (int y = lo; y <= hi; y++) req_q.push_back(Y_BITS'(y));
  endtask

  task automatic pulse_clr();
    @(negedge clk); #1 stat_clr = 1'b1;
    @(negedge clk); #1 stat_clr = 1'b0;
  endtask

  // Raster generator + FIFO model, driven on the falling edge
  initial begin : driver
    logic [1:0] de_sh;
    logic pop;
    de_sh = 2'b00;
    vs_in = 0; hs_in = 0; de_in = 0; de_re_in = 0; fifo_empty = 0; fifo_rd_data = '0;
    forever begin
      @(negedge clk);
      pop = de_re_in && !fifo_empty;
      check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, pop});
      if (pop) begin
        fifo_rd_data = data_ctr;
        data_ctr = data_ctr + 1'b1;
      end
      if (rstn && de_re_in) px_q.push_back(pop ? fifo_rd_data : UFC);
      gh++;
      if (gh == H_TOTAL) begin
        gh = 0;
        gv = (gv + 1) % V_TOTAL;
      end
      de_re_in   = (gh < H_ACT) && (gv < V_ACT);
      de_in      = de_sh[1];
      de_sh      = {de_sh[0], de_re_in};
      hs_in      = (gh >= 20) && (gh < 24);
      vs_in      = (gv == V_ACT + 1);
      fifo_empty = (gv == empty_v) && (gh >= empty_h0) && (gh < empty_h0 + empty_len);
    end
  end

  initial begin : ack_responder
    int ack_cnt;
    ack_cnt = 0;
    line_req_ack = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (line_req) begin
        ack_cnt++;
        line_req_ack = (ack_cnt >= ((32'(line_req_y) == hold_y) ? hold_len : 3));
      end else begin
        ack_cnt = 0;
        line_req_ack = 1'b0;
      end
    end
  end

  initial begin : pixel_mon
    forever begin
      @(posedge clk); #1;
      if (de_out) begin
        pix_cnt++;
        if (px_q.size() == 0) fail_now("unexpected pixel");
        else check("rgb_out", 32'(rgb_out), 32'(px_q.pop_front()));
      end else if (rstn) begin
        check("rgb_blank", 32'(rgb_out), 32'd0);
      end
    end
  end

  initial begin : req_mon
    logic prev;
    logic [Y_BITS-1:0] held;
    prev = 1'b0;
    held = '0;
    forever begin
      @(posedge clk); #1;
      if (line_req && !prev) begin
        if (req_q.size() == 0) fail_now("unexpected line_req");
        else check("line_req_y", 32'(line_req_y), 32'(req_q.pop_front()));
        held = line_req_y;
      end else if (line_req && prev) begin
        check("line_req_y_stable", 32'(line_req_y), 32'(held));
      end
      prev = line_req;
    end
  end

  task automatic check_reset_outputs();
    check("rst vs_out", {31'd0, vs_out}, 0);
    check("rst hs_out", {31'd0, hs_out}, 0);
    check("rst de_out", {31'd0, de_out}, 0);
    check("rst rgb_out", 32'(rgb_out), 0);
    check("rst line_req", {31'd0, line_req}, 0);
    check("rst line_req_y", 32'(line_req_y), 0);
    check("rst underflow", {31'd0, underflow}, 0);
    check("rst underflow_cnt", 32'(underflow_cnt), 0);
    check("rst req_overrun", {31'd0, req_overrun}, 0);
  endtask

  initial begin : main
    int gap;
    rstn = 1'b1; stat_clr = 1'b0;
    #1 rstn = 1'b0;
    #1 check_reset_outputs();
    push_reqs(0, V_ACT - 1);
    repeat (5) @(negedge clk);
    #1 rstn = 1'b1;

    // Frame 1: clean frame, incrementing data from 1
    wait_pos(0, 0);
    wait_pos(V_ACT, 0);
    check("f1 req count", req_q.size(), 0);
    check("f1 pixels", pix_cnt, H_ACT * V_ACT);
    check("f1 underflow", {31'd0, underflow}, 0);
    check("f1 overrun", {31'd0, req_overrun}, 0);
    empty_v = 3; empty_h0 = 4; empty_len = 5;
    push_reqs(0, V_ACT - 1);

    // Frame 2: five starved pixels on line 3
    wait_pos(0, 0);
    wait_pos(V_ACT, 0);
    check("f2 req count", req_q.size(), 0);
    check("f2 underflow", {31'd0, underflow}, 1);
    check("f2 underflow_cnt", 32'(underflow_cnt), 5);
    check("f2 overrun", {31'd0, req_overrun}, 0);
    pulse_clr();
    check("f2 clr underflow", {31'd0, underflow}, 0);
    check("f2 clr underflow_cnt", 32'(underflow_cnt), 0);
    empty_v = 4; empty_h0 = 2; empty_len = 10;
    hold_y = 2; hold_len = H_TOTAL + 5;
    push_reqs(0, V_ACT - 1);

    // Frame 3: ack for line 2 held past the next de_re fall; counter saturates
    wait_pos(0, 0);
    wait_pos(V_ACT, 0);
    check("f3 req count", req_q.size(), 0);
    check("f3 overrun", {31'd0, req_overrun}, 1);
    check("f3 underflow_cnt sat", 32'(underflow_cnt), 7);
    pulse_clr();
    check("f3 clr overrun", {31'd0, req_overrun}, 0);
    empty_v = -1;
    hold_y = V_ACT - 1; hold_len = 3 * H_TOTAL;
    push_reqs(0, V_ACT - 1);
    push_reqs(0, 0);

    // Frame 4: vsync arrives while the last request is still pending
    wait_pos(0, 0);
    wait_pos(V_ACT + 1, 0);
    check("f4 req pending at vs", {31'd0, line_req}, 1);
    check("f4 pending y", 32'(line_req_y), V_ACT - 1);
    for (int i = 0; i < 500 && line_req; i++) begin
      @(negedge clk); #1;
    end
    gap = 0;
    for (int i = 0; i < 50 && !line_req; i++) begin
      @(negedge clk); #1;
      gap++;
    end
    check("f4 idle gap", gap, 1);
    check("f4 restart y", 32'(line_req_y), 0);
    hold_y = -1;
    check("f4 overrun", {31'd0, req_overrun}, 1);
    push_reqs(1, V_ACT - 1);
    pulse_clr();

    // Frame 5: normal frame after the forced restart
    wait_pos(0, 0);
    wait_pos(V_ACT, 0);
    check("f5 req count", req_q.size(), 0);
    check("f5 overrun", {31'd0, req_overrun}, 0);
    check("f5 underflow", {31'd0, underflow}, 0);
    push_reqs(0, 1);

    // Frame 6: asynchronous reset while a request is outstanding
    wait_pos(0, 0);
    for (int i = 0; i < 200 && !line_req; i++) begin
      @(negedge clk); #1;
    end
    check("f6 req before reset", {31'd0, line_req}, 1);
    #2 rstn = 1'b0;
    #1 check_reset_outputs();
    px_q.delete();
    req_q.delete();
    wait_pos(V_ACT, 0);
    rstn = 1'b1;
    push_reqs(0, V_ACT - 1);
    wait_pos(0, 0);
    pix_cnt = 0;
    wait_pos(V_ACT, 0);
    check("f7 req count", req_q.size(), 0);
    check("f7 pixels", pix_cnt, H_ACT * V_ACT);
    check("f7 overrun", {31'd0, req_overrun}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
